mem_bist_ctrl: RTL and testbench



---
 rtl/mem_bist_pkg.sv | 22 ++
 rtl/mem_bist_patgen.sv | 42 ++++
 rtl/mem_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared constants for the memory BIST controller: state encodings, pattern codes, LFSR taps.
// The inverted-pattern pass states are only used when BIST_INV_PASS_EN is defined.
package mem_bist_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_INV_WRITE = 3'd4;
  localparam logic [2:0] ST_INV_READ  = 3'd5;

  localparam logic [1:0] PAT_ADDR  = 2'b00;
  localparam logic [1:0] PAT_CHECK = 2'b01;
  localparam logic [1:0] PAT_ONES  = 2'b10;
  localparam logic [1:0] PAT_LFSR  = 2'b11;

  localparam logic [15:0] CHECK_EVEN = 16'h5555;
  localparam logic [15:0] CHECK_ODD  = 16'hAAAA;
  // Fibonacci x^16+x^14+x^13+x^11+1: feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/mem_bist_patgen.sv
// Pattern generator for the memory BIST: produces write/expected data for an address,
// including the 16-bit LFSR that steps once per completed transfer.
module mem_bist_patgen
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            pat_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  advance_i,
  input  logic                  reload_i,
  input  logic                  invert_i,
  output logic [WIDTH-1:0]      data_o
);

  logic [15:0]      lfsr_q;
  logic [WIDTH-1:0] raw;

  always_ff @(posedge clk_i) begin
    if (rst_i || reload_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance_i) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_comb begin
    raw = '0;
    case (pat_i)
      PAT_ADDR:  raw = WIDTH'(addr_i);
      PAT_CHECK: raw = addr_i[0] ? WIDTH'(CHECK_ODD) : WIDTH'(CHECK_EVEN);
      PAT_ONES:  raw = '1;
      default:   raw = WIDTH'(lfsr_q);
    endcase
    data_o = invert_i ? ~raw : raw;
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master: writes a pattern to every location, reads it back and scores mismatches.
// Define BIST_INV_PASS_EN to add a second write/read pass using the inverted pattern.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            pattern_sel_i,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [ADDR_WIDTH+1:0] err_count_o
);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            pat_q, pat_d;
  logic [ADDR_WIDTH+1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic                  fail_seen_q, fail_seen_d;

  logic             is_write, is_read, invert, active, xfer, last, mismatch;
  logic             advance, reload;
  logic [WIDTH-1:0] pat_data;

  mem_bist_patgen #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LFSR_SEED  (LFSR_SEED)
  ) u_patgen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pat_i     (pat_q),
    .addr_i    (addr_q),
    .advance_i (advance),
    .reload_i  (reload),
    .invert_i  (invert),
    .data_o    (pat_data)
  );

  always_comb begin
    is_write = (state_q == ST_WRITE);
    is_read  = (state_q == ST_READ);
    invert   = 1'b0;
`ifdef BIST_INV_PASS_EN
    is_write = is_write || (state_q == ST_INV_WRITE);
    is_read  = is_read  || (state_q == ST_INV_READ);
    invert   = (state_q == ST_INV_WRITE) || (state_q == ST_INV_READ);
`endif
    active   = is_write || is_read;
    xfer     = active && ready_i;
    last     = (addr_q == ADDR_WIDTH'(DEPTH - 1));
    mismatch = xfer && is_read && (rdata_i != pat_data);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_seen_d = fail_seen_q;
    advance     = 1'b0;
    reload      = 1'b0;

    if ((state_q == ST_IDLE || state_q == ST_DONE) && start_i) begin
      state_d     = ST_WRITE;
      pat_d       = pattern_sel_i;
      addr_d      = '0;
      err_d       = '0;
      fail_addr_d = '0;
      fail_seen_d = 1'b0;
      reload      = 1'b1;
    end

    // Last transfer of a pass rewinds the address and reseeds the LFSR for the next pass
    if (xfer) begin
      if (last) begin
        addr_d = '0;
        reload = 1'b1;
        case (state_q)
          ST_WRITE:     state_d = ST_READ;
`ifdef BIST_INV_PASS_EN
          ST_READ:      state_d = ST_INV_WRITE;
          ST_INV_WRITE: state_d = ST_INV_READ;
          ST_INV_READ:  state_d = ST_DONE;
`else
          ST_READ:      state_d = ST_DONE;
`endif
          default:      state_d = ST_IDLE;
        endcase
      end else begin
        addr_d  = addr_q + 1'b1;
        advance = 1'b1;
      end
    end

    if (mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
      if (!fail_seen_q) begin
        fail_addr_d = addr_q;
        fail_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pat_q       <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  assign valid_o     = active;
  assign wr_rd_o     = is_write;
  assign addr_o      = addr_q;
  assign wdata_o     = is_write ? pat_data : '0;
  assign busy_o      = active;
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = done_o && (err_q == '0);
  assign fail_addr_o = fail_addr_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl with a faultable 16x64 memory model.
module tb_mem_bist_ctrl;

`ifdef BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic        clk, rst, start, valid, wr_rd, rdy, busy, done, pass;
  logic [1:0]  psel;
  logic [5:0]  addr, fail_addr;
  logic [15:0] wdata, rdata;
  logic [7:0]  err_count;

  mem_bist_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pattern_sel_i(psel),
    .valid_o(valid), .wr_rd_o(wr_rd), .addr_o(addr), .wdata_o(wdata),
    .rdata_i(rdata), .ready_i(rdy), .busy_o(busy), .done_o(done),
    .pass_o(pass), .fail_addr_o(fail_addr), .err_count_o(err_count)
  );

  typedef struct { bit wr; int addr; logic [15:0] data; } req_t;
  typedef struct { bit pass; int fa; int ec; } res_t;

  req_t req_q[$];
  res_t res_q[$];

  logic [15:0] mem[64];
  logic [15:0] s0[64];
  logic [15:0] s1[64];
  logic [15:0] lt[64];
  logic [15:0] exp_mem[64];

  int nchk = 0, nfail = 0;
  int ready_mode = 0, stall_id = 0;

  assign rdata = mem[addr];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready driver: one writer only; stall requests arrive as a bumped stall_id
  initial begin
    int seen = 0, low = 0;
    rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_id != seen) begin seen = stall_id; low = 5; end
      if (low > 0) begin rdy = 1'b0; low--; end
      else case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = ~rdy;
      endcase
    end
  end

  // monitor: completes memory writes and scores every transfer and every result
  initial begin
    bit prev_stall = 0, prev_done = 0;
    logic [5:0] p_addr; logic p_wr; logic [15:0] p_wd;
    req_t e; res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; prev_done = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(valid), 32'd1);
          check("stall_wr", 32'(wr_rd), 32'(p_wr));
          check("stall_addr", 32'(addr), 32'(p_addr));
          check("stall_wdata", 32'(wdata), 32'(p_wd));
        end
        if (valid && rdy) begin
          if (req_q.size() == 0) check("unexpected_req", 32'(addr), 32'hFFFF_FFFF);
          else begin
            e = req_q.pop_front();
            check("req_wr", 32'(wr_rd), 32'(e.wr));
            check("req_addr", 32'(addr), 32'(e.addr));
            if (e.wr) check("req_wdata", 32'(wdata), 32'(e.data));
          end
          if (wr_rd) mem[addr] = (wdata & ~s0[addr]) | s1[addr];
        end
        prev_stall = valid && !rdy;
        p_addr = addr; p_wr = wr_rd; p_wd = wdata;
        if (done && !prev_done) begin
          if (res_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            r = res_q.pop_front();
            check("res_pass", 32'(pass), 32'(r.pass));
            check("res_fail_addr", 32'(fail_addr), 32'(r.fa));
            check("res_err_count", 32'(err_count), 32'(r.ec));
            check("res_busy", 32'(busy), 32'd0);
          end
        end
        prev_done = done;
      end
    end
  end

  function automatic logic [15:0] pat(input int sel, input int a, input bit inv);
    logic [15:0] v;
    case (sel)
      0: v = 16'(a);
      1: v = (a % 2 == 1) ? 16'hAAAA : 16'h5555;
      2: v = 16'hFFFF;
      default: v = lt[a];
    endcase
    return inv ? ~v : v;
  endfunction

  task automatic model_push(input int sel);
    int err = 0, first = -1;
    logic [15:0] d;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < 64; a++) begin
        d = pat(sel, a, p == 1);
        req_q.push_back('{1'b1, a, d});
        exp_mem[a] = (d & ~s0[a]) | s1[a];
      end
      for (int a = 0; a < 64; a++) begin
        d = pat(sel, a, p == 1);
        req_q.push_back('{1'b0, a, 16'h0});
        if (exp_mem[a] != d) begin
          if (err < 255) err++;
          if (first < 0) first = a;
        end
      end
    end
    res_q.push_back('{first < 0, (first < 0) ? 0 : first, err});
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 64; a++) begin s0[a] = '0; s1[a] = '0; end
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(posedge clk); #1;
    start = 1'b1; psel = sel;
    @(posedge clk); #1;
    start = 1'b0; psel = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    if (!done) check("done_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    check("queue_drained", 32'(req_q.size() + res_q.size()), 32'd0);
  endtask

  task automatic run_test(input int sel);
    int n;
    model_push(sel);
    pulse_start(2'(sel));
    wait_done(n);
  endtask

  initial begin
    int n, fa, fb;
    rst = 1'b1; start = 1'b0; psel = 2'b00;
    clear_faults();
    for (int a = 0; a < 64; a++) mem[a] = '0;
    lt[0] = 16'hACE1;
    for (int i = 1; i < 64; i++) begin
      fb = int'(lt[i-1][15] ^ lt[i-1][13] ^ lt[i-1][12] ^ lt[i-1][10]);
      lt[i] = {lt[i-1][14:0], 1'(fb)};
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 0); check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);   check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0); check("rst_fail_addr", 32'(fail_addr), 0);
    check("rst_addr", 32'(addr), 0);   check("rst_wdata", 32'(wdata), 0);
    check("rst_wr", 32'(wr_rd), 0);
    rst = 1'b0;

    // 1: ready held high, address pattern, back-to-back transfers
    ready_mode = 0;
    model_push(0);
    pulse_start(2'b00);
    check("t1_valid_after_start", 32'(valid), 1);
    check("t1_busy_after_start", 32'(busy), 1);
    n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    check("t1_cycles", 32'(n), 32'(NPASS * 128 + 1));
    @(posedge clk); #1;
    check("t1_drained", 32'(req_q.size() + res_q.size()), 0);
    check("t1_mem15", 32'(mem[21]), 32'(exp_mem[21]));

    // 2: toggling ready with a 5-cycle stall, checkerboard
    ready_mode = 2;
    model_push(1);
    pulse_start(2'b01);
    repeat (20) @(negedge clk);
    stall_id++;
    wait_done(n);
    check("t2_mem3", 32'(mem[3]), 32'(exp_mem[3]));

    // 3: LFSR pattern, bit 0 of 0x2A stuck opposite to its written value
    ready_mode = 1;
    clear_faults();
    if (lt[42][0]) s0[42] = 16'h0001; else s1[42] = 16'h0001;
    run_test(3);

    // 4: bit 15 stuck at 0 everywhere, all-ones pattern
    clear_faults();
    for (int a = 0; a < 64; a++) s0[a] = 16'h8000;
    run_test(2);

    // 5: reset in the middle of the read pass at address 20
    clear_faults();
    model_push(int'($urandom_range(0, 3)));
    pulse_start(2'b00);
    req_q.delete(); res_q.delete();
    model_push(0);
    n = 0;
    while (!(valid && !wr_rd && addr == 6'd20) && n < 5000) begin @(negedge clk); n++; end
    check("t5_reach_read20", 32'(valid && !wr_rd && addr == 6'd20), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_valid", 32'(valid), 0); check("t5_busy", 32'(busy), 0);
    check("t5_err", 32'(err_count), 0); check("t5_done", 32'(done), 0);
    req_q.delete(); res_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_test(1);

    // 6: starts while busy are ignored; a start in DONE restarts cleanly
    s1[9] = 16'h0100;
    model_push(0);
    pulse_start(2'b00);
    repeat (7) @(negedge clk);
    pulse_start(2'b11);
    repeat (30) @(negedge clk);
    pulse_start(2'b10);
    wait_done(n);
    clear_faults();
    model_push(2);
    pulse_start(2'b10);
    check("t6_done_cleared", 32'(done), 0);
    check("t6_err_cleared", 32'(err_count), 0);
    check("t6_fail_cleared", 32'(fail_addr), 0);
    wait_done(n);

    // random patterns and single-bit faults
    for (int t = 0; t < 4; t++) begin
      clear_faults();
      fa = int'($urandom_range(0, 63));
      fb = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) s1[fa] = 16'(1 << fb); else s0[fa] = 16'(1 << fb);
      ready_mode = int'($urandom_range(0, 2));
      run_test(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
